// File: rtl/uart_rx_if.sv
// Byte-side and line-side signals of the UART receiver. The slave modport is
// the receiver itself; the master modport is the pin driver and byte consumer.
interface uart_rx_if;
  logic       i_rx_serial;
  logic       o_rx_dv;
  logic [7:0] o_rx_byte;
  logic       o_rx_active;
  logic       o_rx_frame_err;
  logic       o_rx_parity_err;

  modport slave (
    input  i_rx_serial,
    output o_rx_dv, o_rx_byte, o_rx_active, o_rx_frame_err, o_rx_parity_err
  );

  modport master (
    output i_rx_serial,
    input  o_rx_dv, o_rx_byte, o_rx_active, o_rx_frame_err, o_rx_parity_err
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver, 8N1 with mid-bit sampling and a break-safe stop-bit error path.
// Define UART_RX_PARITY_EN to add one parity bit (sense set by PARITY_ODD).
module uart_rx #(
  parameter int BAUD_RATE       = 9600,
  parameter int CLOCK_FREQUENCY = 100_000_000,
  parameter int PARITY_ODD      = 0
) (
  input  logic     i_clk,
  input  logic     i_rstn,
  uart_rx_if.slave bus
);
  localparam int CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  // Too few clocks per bit leaves no room for a half-bit start check.
  if (CLKS_PER_BIT < 4 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_cfg_err
    $error("uart_rx: CLKS_PER_BIT must be >= 4 and PARITY_ODD must be 0 or 1");
  end

  logic             rx_meta_q, rx_s_q;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       byte_q, byte_d;
  logic             dv_q, dv_d;
  logic             active_q, active_d;
  logic             ferr_q, ferr_d;
  logic             perr_q, perr_d;
`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
  logic             par_bad_q, par_bad_d;
`endif

  wire mid_bit = (clk_cnt_q == CNT_MID);

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q + CNT_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    dv_d      = 1'b0;
    ferr_d    = 1'b0;
    perr_d    = 1'b0;
    active_d  = active_q;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
`endif
    case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        bit_idx_d = '0;
        active_d  = 1'b0;
        if (!rx_s_q) begin
          state_d  = S_START;
          active_d = 1'b1;
        end
      end
      S_START: begin
        if (clk_cnt_q == CNT_HALF) begin
          clk_cnt_d = '0;
          if (!rx_s_q) begin
            state_d = S_DATA;
          end else begin
            // Line went back high before mid-start: treat as noise.
            state_d  = S_IDLE;
            active_d = 1'b0;
          end
        end
      end
      S_DATA: begin
        if (mid_bit) begin
          clk_cnt_d          = '0;
          shift_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d   = S_PARITY;
`else
            state_d   = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (mid_bit) begin
          clk_cnt_d = '0;
          par_bad_d = rx_s_q ^ (^shift_q) ^ PAR_ODD;
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (mid_bit) begin
          clk_cnt_d = '0;
          if (rx_s_q) begin
            // Leave half a bit early so a back-to-back start edge is caught.
            state_d  = S_IDLE;
            active_d = 1'b0;
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) begin
              perr_d = 1'b1;
            end else begin
              dv_d   = 1'b1;
              byte_d = shift_q;
            end
`else
            dv_d   = 1'b1;
            byte_d = shift_q;
`endif
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        clk_cnt_d = '0;
        if (rx_s_q) begin
          state_d  = S_IDLE;
          active_d = 1'b0;
        end
      end
      default: begin
        state_d   = S_IDLE;
        clk_cnt_d = '0;
        bit_idx_d = '0;
        active_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      dv_q      <= 1'b0;
      active_q  <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      rx_meta_q <= bus.i_rx_serial;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      dv_q      <= dv_d;
      active_q  <= active_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  assign bus.o_rx_dv         = dv_q;
  assign bus.o_rx_byte       = byte_q;
  assign bus.o_rx_active     = active_q;
  assign bus.o_rx_frame_err  = ferr_q;
  assign bus.o_rx_parity_err = perr_q;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: bit-level line driver plus a frame-level expectation queue
// compared against the observed dv / error pulse stream.
module tb_uart_rx;
  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS  = 11;
  localparam bit PAR_EN = 1'b1;
`else
  localparam int NBITS  = 10;
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int FRAME = NBITS * CPB;
  localparam int LAT   = 3 + CPB / 2 + (NBITS - 1) * CPB;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  uart_rx_if bus ();

  uart_rx #(.BAUD_RATE(10), .CLOCK_FREQUENCY(160), .PARITY_ODD(0)) dut (
    .i_clk (clk),
    .i_rstn(rstn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Events as {kind, byte}: kind 1 = good byte, 2 = frame error, 3 = parity error.
  logic [9:0] exp_q[$];
  logic [9:0] obs_q[$];
  logic [7:0] last_good = 8'h00;
  logic [7:0] prev_byte = 8'h00;
  int overlap_cnt = 0;
  int byte_glitch = 0;

  always @(negedge clk) begin
    if (bus.o_rx_dv)         obs_q.push_back({2'd1, bus.o_rx_byte});
    if (bus.o_rx_frame_err)  obs_q.push_back({2'd2, 8'h00});
    if (bus.o_rx_parity_err) obs_q.push_back({2'd3, 8'h00});
    if (int'(bus.o_rx_dv) + int'(bus.o_rx_frame_err) + int'(bus.o_rx_parity_err) > 1)
      overlap_cnt++;
    if (rstn && !bus.o_rx_dv && bus.o_rx_byte != prev_byte) byte_glitch++;
    prev_byte = bus.o_rx_byte;
  end

  // Drives one frame from the caller's negedge; a truncated frame adds no expectation.
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_flip,
                            input int max_clks);
    logic bits[$];
    int n;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    if (PAR_EN) bits.push_back((^b) ^ 1'b0 ^ par_flip);
    bits.push_back(stop_v);
    n = 0;
    foreach (bits[i]) begin
      for (int c = 0; c < CPB; c++) begin
        if (n == max_clks) return;
        bus.i_rx_serial = bits[i];
        @(negedge clk);
        n++;
      end
    end
    if (!stop_v)                exp_q.push_back({2'd2, 8'h00});
    else if (PAR_EN && par_flip) exp_q.push_back({2'd3, 8'h00});
    else begin
      exp_q.push_back({2'd1, b});
      last_good = b;
    end
  endtask

  task automatic idle(input int n);
    bus.i_rx_serial = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_events(input string tag);
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0)
      chk(tag, obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nz, lat, act_low;
    logic [7:0] b;
    bus.i_rx_serial = 1'b1;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {bus.o_rx_dv, bus.o_rx_active, bus.o_rx_frame_err,
                        bus.o_rx_parity_err, bus.o_rx_byte}, 32'h0);
    rstn = 1'b1;

    nz = 0;
    repeat (500) begin
      @(negedge clk);
      if (bus.o_rx_dv || bus.o_rx_active || bus.o_rx_frame_err ||
          bus.o_rx_parity_err || bus.o_rx_byte != 8'h00) nz++;
    end
    chk("idle_quiet", nz, 0);

    lat = 0;
    act_low = 0;
    fork
      send_frame(8'hA5, 1'b1, 1'b0, FRAME);
      begin
        while (lat < 400) begin
          @(posedge clk);
          lat++;
          @(negedge clk);
          if (bus.o_rx_dv) break;
          if (lat >= 3 && !bus.o_rx_active) act_low++;
        end
      end
    join
    chk("latency", lat, LAT);
    chk("active_in_frame", act_low, 0);
    chk("byte_a5", bus.o_rx_byte, 8'hA5);
    idle(20);
    check_events("single");

    send_frame(8'h00, 1'b1, 1'b0, FRAME);
    send_frame(8'hFF, 1'b1, 1'b0, FRAME);
    send_frame(8'h5A, 1'b1, 1'b0, FRAME);
    idle(40);
    check_events("b2b");

    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, PAR_EN && ($urandom_range(0, 7) == 0), FRAME);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 40));
    end
    idle(40);
    check_events("random");
    chk("random_last_byte", bus.o_rx_byte, last_good);
    chk("active_after_random", bus.o_rx_active, 1'b0);

    bus.i_rx_serial = 1'b0;
    repeat (5) @(negedge clk);
    bus.i_rx_serial = 1'b1;
    repeat (2) @(negedge clk);
    chk("glitch_active_hi", bus.o_rx_active, 1'b1);
    idle(40);
    chk("glitch_active_lo", bus.o_rx_active, 1'b0);
    check_events("glitch");

    b = last_good;
    send_frame(8'h3C, 1'b0, 1'b0, FRAME);
    bus.i_rx_serial = 1'b0;
    repeat (100) @(negedge clk);
    chk("break_byte_kept", bus.o_rx_byte, b);
    idle(40);
    chk("break_active_lo", bus.o_rx_active, 1'b0);
    send_frame(8'h81, 1'b1, 1'b0, FRAME);
    idle(40);
    check_events("frame_err");
    chk("byte_81", bus.o_rx_byte, 8'h81);

    chk("byte_stable", byte_glitch, 0);
    chk("pulse_overlap", overlap_cnt, 0);

    send_frame(8'h7E, 1'b1, 1'b0, 4 * CPB + CPB / 2);
    chk("pre_rst_active", bus.o_rx_active, 1'b1);
    #3 rstn = 1'b0;
    #1 chk("mid_rst_outputs", {bus.o_rx_dv, bus.o_rx_active, bus.o_rx_frame_err,
                               bus.o_rx_parity_err, bus.o_rx_byte}, 32'h0);
    bus.i_rx_serial = 1'b1;
    last_good = 8'h00;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    idle(40);
    check_events("rst_abort");
    send_frame(8'h7E, 1'b1, 1'b0, FRAME);
    idle(40);
    check_events("after_rst");
    chk("byte_7e", bus.o_rx_byte, 8'h7E);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, FRAME);
    idle(20);
    check_events("parity_good");
    send_frame(8'h07, 1'b1, 1'b1, FRAME);
    idle(20);
    check_events("parity_bad");
    chk("parity_byte_kept", bus.o_rx_byte, 8'h07);
    send_frame(8'h55, 1'b0, 1'b1, FRAME);
    idle(40);
    check_events("parity_vs_stop");
`endif

    chk("byte_stable_end", byte_glitch, 0);
    chk("pulse_overlap_end", overlap_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver, the counterpart of the existing uart_tx.
- Frame format: 8N1 (start bit, 8 data bits LSB first, stop bit). An optional parity bit is added when the macro in Optional Feature is defined.
- Synchronises the asynchronous serial line, detects the start bit, and samples each bit at its midpoint.
- Presents each received byte with a one-cycle valid strobe.
- Sits between the board RX pin and the byte-level consumer (loopback against uart_tx, command parser).

Parameters:
BAUD_RATE, 9600, serial bit rate in bits/s
CLOCK_FREQUENCY, 100_000_000, i_clk frequency in Hz
PARITY_ODD, 0, parity sense when UART_RX_PARITY_EN is defined: 0 = even, 1 = odd; ignored otherwise
Derived (localparams, not ports):
- CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE; must be >= 4.
- HALF_BIT = CLKS_PER_BIT / 2.

Ports:
i_clk  input  1  system clock
i_rstn  input  1  reset, asynchronous assert, active low
i_rx_serial  input  1  asynchronous serial line, idle high
o_rx_dv  output  1  one-cycle pulse: o_rx_byte holds a newly received good byte
o_rx_byte  output  8  last good received byte
o_rx_active  output  1  high while a frame is being received
o_rx_frame_err  output  1  one-cycle pulse: stop bit sampled low
o_rx_parity_err  output  1  one-cycle pulse: parity mismatch (tied 0 when feature is off)

Behaviour:
- Clocking and reset: one clock, i_clk. Reset is asynchronous and active-low via i_rstn, polarity and synchronicity fixed.
- Reset values: all outputs 0; state IDLE; counters 0; synchroniser flops 1 (line idle).
- Reset asserted mid-frame: abort immediately, return to IDLE, no o_rx_dv and no error pulse for the aborted frame.
- Input path: i_rx_serial passes through a 2-flop synchroniser. All decisions use the synchronised value rx_s.
- Counters:
  - clk_cnt is $clog2(CLKS_PER_BIT) bits wide and resets to 0 on every state change.
  - bit_index is 3 bits.
- State machine: IDLE, START_BIT, DATA_BYTE, PARITY_BIT (feature only), STOP_BIT, BREAK_WAIT.
- IDLE:
  - o_rx_active = 0.
  - rx_s == 0 -> START_BIT, o_rx_active <= 1.
- START_BIT:
  - Count to HALF_BIT-1, then re-check rx_s.
  - rx_s still 0 -> DATA_BYTE.
  - rx_s == 1 -> glitch: return to IDLE, drop o_rx_active, no pulse.
- DATA_BYTE:
  - At clk_cnt == CLKS_PER_BIT-1 (mid-bit), store rx_s into byte bit bit_index, LSB first.
  - After bit 7 -> PARITY_BIT if the feature is enabled, else STOP_BIT; bit_index resets to 0.
- STOP_BIT, mid-bit sample:
  - rx_s == 1: o_rx_byte <= shift register and o_rx_dv <= 1 for exactly one cycle, unless parity failed. Then go to IDLE with o_rx_active <= 0.
  - rx_s == 0: o_rx_frame_err <= 1 for one cycle; o_rx_byte is unchanged and no o_rx_dv. Go to BREAK_WAIT.
- BREAK_WAIT: wait until rx_s == 1, then go to IDLE with o_rx_active <= 0. A held-low (break) line therefore produces exactly one frame error, not repeated frames.
- Latency: the i_rx_serial falling edge to the o_rx_dv rising edge is 3 + HALF_BIT + 9*CLKS_PER_BIT clocks, or +CLKS_PER_BIT with parity enabled.
- Back-to-back frames: a start bit arriving right after the stop-bit midpoint is accepted. IDLE is re-entered half a bit before the end of the stop bit.
- o_rx_dv and the error pulses are never high in the same cycle.
- o_rx_byte changes only together with an o_rx_dv pulse.
- No back-pressure: the consumer must capture o_rx_byte within one frame time.

Optional Feature:
Macro: UART_RX_PARITY_EN.
- Defined:
  - One parity bit follows data bit 7, sampled mid-bit in PARITY_BIT.
  - Expected value = XOR of the 8 data bits, XOR PARITY_ODD.
  - On mismatch, the following stop-bit sample (if good) pulses o_rx_parity_err for one cycle instead of o_rx_dv; o_rx_byte is unchanged.
  - A stop-bit error takes precedence: only o_rx_frame_err pulses.
- Not defined:
  - PARITY_BIT state and parity logic are absent.
  - o_rx_parity_err is tied to 0.
  - Frame is 8N1.

Test Plan:
All scenarios use CLOCK_FREQUENCY=160, BAUD_RATE=10 (CLKS_PER_BIT=16).
- Reset and idle: line held high for 500 clocks after reset -> all outputs remain 0.
- Single byte: drive 8'hA5 as 8N1 from a bit-accurate model -> one o_rx_dv pulse, 155 clocks after the start edge, with o_rx_byte=8'hA5. o_rx_active is high from start to the dv pulse.
- Back-to-back: 8'h00, 8'hFF, 8'h5A with no idle gap, then uart_tx loopback of 256 random bytes -> each byte received in order, one dv each, no errors.
- Glitch and frame error:
  - 5-clock low pulse on an idle line -> no dv; o_rx_active drops.
  - Byte 8'h3C sent with stop bit forced 0 and the line held low 100 clocks -> one o_rx_frame_err pulse, o_rx_byte unchanged, recovers and receives a following 8'h81.
- Reset mid-frame: assert i_rstn=0 asynchronously during data bit 3 -> outputs 0 immediately, no dv. The next full frame 8'h7E is received correctly.
- Parity (UART_RX_PARITY_EN, PARITY_ODD=0):
  - 8'h07 with parity bit 1 -> dv.
  - 8'h07 with parity bit 0 -> o_rx_parity_err pulse, no dv.
